// File: rtl/chip8_fetch_sequencer_if.sv
// Bus bundle between the CHIP-8 fetch sequencer and its surroundings:
// program memory read port, decoder/register-file taps and execute handshake.
// The sequencer uses the master modport; memory, datapath and bench use slave.
interface chip8_fetch_sequencer_if;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [15:0] opcode;
    logic [11:0] pc;
    logic [7:0]  vx;
    logic [7:0]  vy;
    logic [7:0]  v0;
    logic        key_match;
    logic        exec_start;
    logic        exec_done;
    logic        fault;

    modport master (
        output mem_addr, mem_rd, opcode, pc, exec_start, fault,
        input  mem_rdata, mem_ready, vx, vy, v0, key_match, exec_done
    );

    modport slave (
        input  mem_addr, mem_rd, opcode, pc, exec_start, fault,
        output mem_rdata, mem_ready, vx, vy, v0, key_match, exec_done
    );
endinterface

// File: rtl/chip8_fetch_sequencer.sv
// CHIP-8 instruction fetch/sequence controller.
// Fetches big-endian 16-bit opcodes from byte memory, resolves jumps,
// call/return and skips itself, and hands every other opcode to the execute
// datapath through the exec_start/exec_done handshake. Owns PC and call stack.
// Optional single-step support is enabled by defining CHIP8_SEQ_SINGLE_STEP_EN,
// which adds run/step inputs and a PAUSE state between instructions.
module chip8_fetch_sequencer #(
    parameter logic [11:0] PC_RESET    = 12'h200,
    parameter int          STACK_DEPTH = 16
) (
    input  logic clk,
    input  logic reset_n,
`ifdef CHIP8_SEQ_SINGLE_STEP_EN
    input  logic run,
    input  logic step,
`endif
    chip8_fetch_sequencer_if.master bus
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SP_W  = IDX_W + 1;

    typedef enum logic [2:0] {
        ST_FETCH_HI  = 3'd0,
        ST_FETCH_LO  = 3'd1,
        ST_DISPATCH  = 3'd2,
        ST_EXEC_WAIT = 3'd3,
        ST_HALT      = 3'd4
`ifdef CHIP8_SEQ_SINGLE_STEP_EN
        , ST_PAUSE   = 3'd5
`endif
    } state_e;

    // State entered after reset and after every completed instruction.
`ifdef CHIP8_SEQ_SINGLE_STEP_EN
    localparam state_e ST_NEXT_INSTR = ST_PAUSE;
`else
    localparam state_e ST_NEXT_INSTR = ST_FETCH_HI;
`endif

    state_e            state_q, state_d;
    logic [11:0]       pc_q, pc_d;
    logic [15:0]       opcode_q, opcode_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              fault_q, fault_d;
    logic [11:0]       stack_q [STACK_DEPTH];
    logic              push_en;
    logic              dispatch_ctrl;
    logic [IDX_W-1:0]  pop_idx;
    logic [IDX_W-1:0]  push_idx;

    assign pop_idx  = IDX_W'(sp_q - SP_W'(1'b1));
    assign push_idx = sp_q[IDX_W-1:0];

    // State register; reset restarts fetching (or pausing) from PC_RESET.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_NEXT_INSTR;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: PC, latched opcode, stack pointer and sticky fault.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q     <= PC_RESET;
            opcode_q <= 16'h0000;
            sp_q     <= '0;
            fault_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            sp_q     <= sp_d;
            fault_q  <= fault_d;
        end
    end

    // Register-based call stack; a call stores the address of the call opcode.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= 12'h000;
            end
        end else if (push_en) begin
            stack_q[push_idx] <= pc_q;
        end else begin
            stack_q <= stack_q;
        end
    end

    // Next-state logic including control-flow resolution during DISPATCH.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        opcode_d      = opcode_q;
        sp_d          = sp_q;
        fault_d       = fault_q;
        push_en       = 1'b0;
        dispatch_ctrl = 1'b0;
        case (state_q)
            ST_FETCH_HI: begin
                if (bus.mem_ready) begin
                    opcode_d[15:8] = bus.mem_rdata;
                    state_d        = ST_FETCH_LO;
                end else begin
                    state_d = ST_FETCH_HI;
                end
            end
            ST_FETCH_LO: begin
                if (bus.mem_ready) begin
                    opcode_d[7:0] = bus.mem_rdata;
                    state_d       = ST_DISPATCH;
                end else begin
                    state_d = ST_FETCH_LO;
                end
            end
            ST_DISPATCH: begin
                // Assume control flow; opcodes that need the datapath clear it.
                dispatch_ctrl = 1'b1;
                case (opcode_q[15:12])
                    4'h0: begin
                        if (opcode_q == 16'h00EE) begin
                            if (sp_q == '0) begin
                                fault_d = 1'b1;
                            end else begin
                                sp_d = sp_q - SP_W'(1'b1);
                                pc_d = stack_q[pop_idx] + 12'd2;
                            end
                        end else begin
                            dispatch_ctrl = 1'b0;
                        end
                    end
                    4'h1: pc_d = opcode_q[11:0];
                    4'h2: begin
                        if (sp_q == SP_W'(STACK_DEPTH)) begin
                            fault_d = 1'b1;
                        end else begin
                            push_en = 1'b1;
                            sp_d    = sp_q + SP_W'(1'b1);
                            pc_d    = opcode_q[11:0];
                        end
                    end
                    4'hB: pc_d = opcode_q[11:0] + {4'h0, bus.v0};
                    4'h3: pc_d = pc_q + ((bus.vx == opcode_q[7:0]) ? 12'd4 : 12'd2);
                    4'h4: pc_d = pc_q + ((bus.vx != opcode_q[7:0]) ? 12'd4 : 12'd2);
                    4'h5: begin
                        if (opcode_q[3:0] == 4'h0) begin
                            pc_d = pc_q + ((bus.vx == bus.vy) ? 12'd4 : 12'd2);
                        end else begin
                            dispatch_ctrl = 1'b0;
                        end
                    end
                    4'h9: begin
                        if (opcode_q[3:0] == 4'h0) begin
                            pc_d = pc_q + ((bus.vx != bus.vy) ? 12'd4 : 12'd2);
                        end else begin
                            dispatch_ctrl = 1'b0;
                        end
                    end
                    4'hE: begin
                        if (opcode_q[7:0] == 8'h9E) begin
                            pc_d = pc_q + (bus.key_match ? 12'd4 : 12'd2);
                        end else if (opcode_q[7:0] == 8'hA1) begin
                            pc_d = pc_q + (bus.key_match ? 12'd2 : 12'd4);
                        end else begin
                            dispatch_ctrl = 1'b0;
                        end
                    end
                    default: dispatch_ctrl = 1'b0;
                endcase
                if (fault_d) begin
                    state_d = ST_HALT;
                end else if (dispatch_ctrl) begin
                    state_d = ST_NEXT_INSTR;
                end else begin
                    state_d = ST_EXEC_WAIT;
                end
            end
            ST_EXEC_WAIT: begin
                if (bus.exec_done) begin
                    pc_d    = pc_q + 12'd2;
                    state_d = ST_NEXT_INSTR;
                end else begin
                    state_d = ST_EXEC_WAIT;
                end
            end
            ST_HALT: state_d = ST_HALT;
`ifdef CHIP8_SEQ_SINGLE_STEP_EN
            ST_PAUSE: begin
                if (run || step) begin
                    state_d = ST_FETCH_HI;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
`endif
            default: begin
                // Corrupted state encoding: stop the core and flag it.
                fault_d = 1'b1;
                state_d = ST_HALT;
            end
        endcase
    end

    // Moore outputs; bus requests are suppressed while reset is held.
    always_comb begin
        bus.mem_rd     = 1'b0;
        bus.mem_addr   = pc_q;
        bus.exec_start = 1'b0;
        case (state_q)
            ST_FETCH_HI: begin
                bus.mem_rd   = reset_n;
                bus.mem_addr = pc_q;
            end
            ST_FETCH_LO: begin
                bus.mem_rd   = reset_n;
                bus.mem_addr = pc_q + 12'd1;
            end
            ST_DISPATCH: bus.exec_start = reset_n & ~dispatch_ctrl;
            default: begin
                bus.mem_rd     = 1'b0;
                bus.exec_start = 1'b0;
            end
        endcase
    end

    assign bus.opcode = opcode_q;
    assign bus.pc     = pc_q;
    assign bus.fault  = fault_q;

endmodule
